// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and widths for the two-port line-memory arbiter.
package mem_arbiter_pkg;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } arb_state_t;
endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog: counts grant cycles without ack and emits a single timeout
// pulse per grant in the cycle the count reaches TIMEOUT; cleared while idle.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic busy,
    input  logic ack,
    output logic timeout
);
    localparam logic [TO_W-1:0] LIMIT   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] CNT_MAX = '1;

    logic [TO_W-1:0] cnt;
    logic            fired;

    // Pulse on the busy cycle that brings the count up to TIMEOUT.
    assign timeout = busy && !ack && !fired && (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            fired <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            fired <= 1'b0;
        end else if (busy && !ack) begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (timeout) begin
                fired <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the data and instruction caches onto one line-wide memory; grant one
// cycle after request, ack combinational, one forced idle cycle between transactions.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 1023,
    parameter int TO_W       = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              d_mem_enable_i,
    input  logic              d_mem_write_i,
    input  logic [ADDR_W-1:0] d_mem_addr_i,
    input  logic [LINE_W-1:0] d_mem_data_i,
    output logic              d_mem_ack_o,
    output logic [LINE_W-1:0] d_mem_data_o,
    input  logic              i_mem_enable_i,
    input  logic              i_mem_write_i,
    input  logic [ADDR_W-1:0] i_mem_addr_i,
    input  logic [LINE_W-1:0] i_mem_data_i,
    output logic              i_mem_ack_o,
    output logic [LINE_W-1:0] i_mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              err_o
);
    arb_state_t state;
    logic       last_served;
    logic       wd_timeout;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .clear   (state == IDLE),
        .busy    (state != IDLE),
        .ack     (mem_ack_i),
        .timeout (wd_timeout)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            last_served <= PORT_I;
            err_o       <= 1'b0;
        end else begin
            if (wd_timeout) begin
                err_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // D wins when alone, under fixed priority, or when I went last.
                    if (d_mem_enable_i &&
                        (!i_mem_enable_i || FIXED_PRIO != 0 || last_served == PORT_I)) begin
                        state <= GRANT_D;
                    end else if (i_mem_enable_i) begin
                        state <= GRANT_I;
                    end
                end
                GRANT_D: begin
                    if (mem_ack_i) begin
                        state       <= IDLE;
                        last_served <= PORT_D;
                    end else if (!d_mem_enable_i) begin
                        state <= IDLE;
                        err_o <= 1'b1;
                    end
                end
                GRANT_I: begin
                    if (mem_ack_i) begin
                        state       <= IDLE;
                        last_served <= PORT_I;
                    end else if (!i_mem_enable_i) begin
                        state <= IDLE;
                        err_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        d_mem_ack_o  = 1'b0;
        i_mem_ack_o  = 1'b0;
        case (state)
            GRANT_D: begin
                mem_enable_o = d_mem_enable_i;
                mem_write_o  = d_mem_write_i;
                mem_addr_o   = d_mem_addr_i;
                mem_data_o   = d_mem_data_i;
                d_mem_ack_o  = mem_ack_i;
            end
            GRANT_I: begin
                mem_enable_o = i_mem_enable_i;
                mem_write_o  = i_mem_write_i;
                mem_addr_o   = i_mem_addr_i;
                mem_data_o   = i_mem_data_i;
                i_mem_ack_o  = mem_ack_i;
            end
            default: ;
        endcase
    end

    assign d_mem_data_o = mem_data_i;
    assign i_mem_data_o = mem_data_i;
endmodule
